// File: rtl/switch_arbiter.sv
// Output-port allocator for the 4-port switch: round-robin, all-or-nothing
// allocation of unicast/multicast requests with per-input starvation counters.
module switch_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic [3:0] dst0_i,
  input  logic [3:0] dst1_i,
  input  logic [3:0] dst2_i,
  input  logic [3:0] dst3_i,
  output logic [3:0] grant_o,
  output logic [1:0] mux_sel0_o,
  output logic [1:0] mux_sel1_o,
  output logic [1:0] mux_sel2_o,
  output logic [1:0] mux_sel3_o,
  output logic [3:0] arb_active_o,
  output logic [1:0] rr_ptr_o,
  output logic       req_err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [3:0][3:0]       dst_s;
  logic [3:0]            elig_s;
  logic [3:0]            win_s;
  logic [3:0]            free_s;
  logic [1:0]            start_s;
  logic [1:0]            idx_s;
  logic [1:0]            first_s;
  logic                  first_found_s;
  logic                  starve_found_s;
  logic [3:0]            grant_q, grant_d;
  logic [3:0]            active_q, active_d;
  logic [3:0][1:0]       sel_q, sel_d;
  logic [1:0]            rr_q, rr_d;
  logic [3:0][CNT_W-1:0] wait_q, wait_d;
  logic                  err_q, err_d;

  assign dst_s = {dst3_i, dst2_i, dst1_i, dst0_i};

  // Eligibility: live request with a non-empty mask, not granted last cycle.
  always_comb begin
    elig_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      elig_s[i] = req_i[i] & (dst_s[i] != 4'b0000) & ~grant_q[i];
    end
  end

  // Scan inputs from the start index, granting whole masks that still fit.
  always_comb begin
    start_s        = rr_q;
    starve_found_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!starve_found_s && (wait_q[i] == MAX_CNT)) begin
        start_s        = 2'(i);
        starve_found_s = 1'b1;
      end else begin
        start_s = start_s;
      end
    end
    free_s        = 4'b1111;
    win_s         = 4'b0000;
    first_s       = 2'd0;
    first_found_s = 1'b0;
    idx_s         = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = start_s + 2'(k);
      if (elig_s[idx_s] && ((dst_s[idx_s] & ~free_s) == 4'b0000)) begin
        win_s[idx_s] = 1'b1;
        free_s       = free_s & ~dst_s[idx_s];
        if (!first_found_s) begin
          first_s       = idx_s;
          first_found_s = 1'b1;
        end else begin
          first_found_s = 1'b1;
        end
      end else begin
        free_s = free_s;
      end
    end
  end

  // Next-state for outputs, round-robin pointer and starvation counters.
  always_comb begin
    grant_d  = win_s;
    active_d = 4'b0000;
    sel_d    = sel_q;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (win_s[i] && dst_s[i][j]) begin
          active_d[j] = 1'b1;
          sel_d[j]    = 2'(i);
        end else begin
          active_d[j] = active_d[j];
        end
      end
    end
    if (first_found_s) begin
      rr_d = first_s + 2'd1;
    end else begin
      rr_d = rr_q;
    end
    wait_d = wait_q;
    for (int i = 0; i < 4; i++) begin
      if (win_s[i] || !req_i[i]) begin
        wait_d[i] = '0;
      end else if (elig_s[i] && (wait_q[i] != MAX_CNT)) begin
        wait_d[i] = wait_q[i] + CNT_W'(1);
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
    err_d = |(req_i & {dst3_i == 4'b0000, dst2_i == 4'b0000,
                       dst1_i == 4'b0000, dst0_i == 4'b0000});
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= 4'b0000;
      active_q <= 4'b0000;
      sel_q    <= '0;
      rr_q     <= 2'd0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      active_q <= active_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  assign grant_o      = grant_q;
  assign arb_active_o = active_q;
  assign mux_sel0_o   = sel_q[0];
  assign mux_sel1_o   = sel_q[1];
  assign mux_sel2_o   = sel_q[2];
  assign mux_sel3_o   = sel_q[3];
  assign rr_ptr_o     = rr_q;
  assign req_err_o    = err_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Self-checking bench for switch_arbiter: directed vector table, corner-case
// sequences and random traffic against a behavioural allocation model.
module tb_switch_arbiter;

  localparam int MAXW = 3;
  localparam int CW   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] dst0 = 4'b0000, dst1 = 4'b0000, dst2 = 4'b0000, dst3 = 4'b0000;
  logic [3:0] grant, arb_active;
  logic [1:0] sel0, sel1, sel2, sel3, rr_ptr;
  logic       req_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model state
  logic [3:0] m_grant, m_active;
  logic [1:0] m_sel[4];
  int         m_rr;
  int         m_wait[4];
  logic       m_err;

  typedef struct {
    logic [3:0] req;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] grant;
    logic [3:0] active;
    logic [7:0] sel;
    logic [1:0] rr;
    logic       err;
  } vec_t;

  vec_t tbl[10];

  switch_arbiter #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .dst0_i(dst0), .dst1_i(dst1), .dst2_i(dst2), .dst3_i(dst3),
    .grant_o(grant),
    .mux_sel0_o(sel0), .mux_sel1_o(sel1), .mux_sel2_o(sel2), .mux_sel3_o(sel3),
    .arb_active_o(arb_active), .rr_ptr_o(rr_ptr), .req_err_o(req_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    req = r; dst0 = a; dst1 = b; dst2 = c; dst3 = d;
  endtask

  task automatic model_reset();
    m_grant = 4'b0000; m_active = 4'b0000; m_rr = 0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sel[i] = 2'd0;
      m_wait[i] = 0;
    end
  endtask

  // One allocation step straight from the rules: pick a start, walk the ring,
  // hand out whole masks from a free set.
  task automatic model_step();
    logic [3:0] d[4];
    logic [3:0] elig, free, win;
    int start, first, p;
    d[0] = dst0; d[1] = dst1; d[2] = dst2; d[3] = dst3;
    for (int i = 0; i < 4; i++) elig[i] = req[i] && (d[i] != 4'b0000) && !m_grant[i];
    start = m_rr;
    for (int i = 3; i >= 0; i--) if (m_wait[i] == MAXW) start = i;
    free = 4'b1111; win = 4'b0000; first = -1;
    for (int k = 0; k < 4; k++) begin
      p = (start + k) % 4;
      if (elig[p] && ((d[p] & ~free) == 4'b0000)) begin
        win[p] = 1'b1;
        free = free & ~d[p];
        if (first < 0) first = p;
      end
    end
    m_active = ~free;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (win[i] && d[i][j]) m_sel[j] = 2'(i);
    if (first >= 0) m_rr = (first + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (win[i] || !req[i]) m_wait[i] = 0;
      else if (elig[i] && m_wait[i] < MAXW) m_wait[i] = m_wait[i] + 1;
    end
    m_err = 1'b0;
    for (int i = 0; i < 4; i++) if (req[i] && d[i] == 4'b0000) m_err = 1'b1;
    m_grant = win;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("grant", {4'b0, grant}, {4'b0, m_grant});
    chk("active", {4'b0, arb_active}, {4'b0, m_active});
    chk("mux_sel", {sel3, sel2, sel1, sel0}, {m_sel[3], m_sel[2], m_sel[1], m_sel[0]});
    chk("rr_ptr", {6'b0, rr_ptr}, 8'(m_rr));
    chk("req_err", {7'b0, req_err}, {7'b0, m_err});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, {4'b0, grant}, 8'h00);
    chk({tag, "_active"}, {4'b0, arb_active}, 8'h00);
    chk({tag, "_sel"}, {sel3, sel2, sel1, sel0}, 8'h00);
    chk({tag, "_rr"}, {6'b0, rr_ptr}, 8'h00);
    chk({tag, "_err"}, {7'b0, req_err}, 8'h00);
  endtask

  initial begin
    int got;
    //         req      d0       d1       d2       d3       grant    active   sel    rr    err
    tbl[0] = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 8'h00, 2'd1, 1'b0};
    tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd1, 1'b0};
    tbl[2] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0001, 8'h03, 2'd0, 1'b0};
    tbl[3] = '{4'b0101, 4'b0011, 4'b0000, 4'b1100, 4'b0000, 4'b0101, 4'b1111, 8'hA0, 2'd1, 1'b0};
    tbl[4] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'hA0, 2'd1, 1'b1};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'hA0, 2'd1, 1'b0};
    tbl[6] = '{4'b0011, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 8'hA1, 2'd2, 1'b0};
    tbl[7] = '{4'b0011, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 8'h00, 2'd1, 1'b0};
    tbl[8] = '{4'b0011, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 8'h01, 2'd2, 1'b0};
    tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h01, 2'd2, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // directed vectors
    for (int v = 0; v < 10; v++) begin
      set_in(tbl[v].req, tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].d3);
      cycle();
      chk($sformatf("tbl%0d_grant", v), {4'b0, grant}, {4'b0, tbl[v].grant});
      chk($sformatf("tbl%0d_active", v), {4'b0, arb_active}, {4'b0, tbl[v].active});
      chk($sformatf("tbl%0d_sel", v), {sel3, sel2, sel1, sel0}, tbl[v].sel);
      chk($sformatf("tbl%0d_rr", v), {6'b0, rr_ptr}, {6'b0, tbl[v].rr});
      chk($sformatf("tbl%0d_err", v), {7'b0, req_err}, {7'b0, tbl[v].err});
    end

    // two inputs fighting for output 1 alternate, mux_sel1 tracks the winner
    set_in(4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("conflict%0d_grant", k), {4'b0, grant}, (k % 2 == 0) ? 8'h01 : 8'h02);
      chk($sformatf("conflict%0d_sel1", k), {6'b0, sel1}, 8'(k % 2));
    end

    // asynchronous reset while a grant is on the outputs
    chk("pre_rst_grant", {4'b0, grant}, 8'h02);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    set_in(4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;

    // input 3 must be served within the starvation bound
    got = -1;
    for (int c = 0; c < MAXW + 3; c++) begin
      cycle();
      if (got < 0 && grant[3] === 1'b1) got = c;
    end
    chk("starve_bound", {7'b0, (got >= 0 && got <= MAXW)}, 8'h01);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 9) < 8);
      dst0 = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      dst1 = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      dst2 = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      dst3 = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
